packet_scheduler: RTL and testbench
===================================

// Module: packet_scheduler
// PURPOSE
//  Arbitrates data-island packet slots in the HDMI clk_pixel domain. It chooses which packet type
//  fills each slot: audio sample, audio clock regeneration (ACR), per-field InfoFrames, or null.
//  Sits between the timing/data-island generator (slot strobes) and the packet mux (packet_type).
//  Adds an ACR anti-starvation guard, round-robin InfoFrames and a slot-overrun monitor.
// PARAMETERS
//  NUM_IF          3           number of InfoFrame requesters (1..8)
//  IF_TYPES        24'h838284  packed 8-bit packet types; bits [8i+7:8i] = InfoFrame i (0x84,0x82,0x83)
//  STARVE_LIMIT    4           consecutive audio wins while ACR pending before ACR is forced (1..15)
// PORTS
//  clk_pixel        in   1        pixel clock
//  reset_n          in   1        async active-low reset
//  video_field_end  in   1        1-cycle pulse at end of each video field
//  packet_enable    in   1        1-cycle pulse at start of a 32-cycle packet slot
//  audio_req        in   1        level: audio samples buffered
//  audio_ack        out  1        1-cycle pulse: audio granted this slot
//  acr_req          in   1        level: new ACR values ready
//  acr_ack          out  1        1-cycle pulse: ACR granted this slot
//  if_enable        in   NUM_IF   static mask: InfoFrame i sent once per field
//  if_ack           out  NUM_IF   one-hot 1-cycle pulse: InfoFrame i granted
//  packet_type      out  8        type selected for the current slot
//  field_done       out  1        all enabled InfoFrames sent this field
//  slot_overrun     out  1        sticky: packet_enable seen mid-slot
// BEHAVIOUR
//  Reset: packet_type=0, all acks 0, field_done=0, slot_overrun=0, if_pending=0, rr_ptr=0,
//   starve_cnt=0, slot_cnt=0, state=IDLE. Async assert; deassert is synchronised upstream.
//  FSM: IDLE --packet_enable--> SLOT. SLOT counts slot_cnt 0..31; at 31 -> IDLE.
//   A packet_enable when slot_cnt=31 is accepted (back-to-back): stays in SLOT, slot_cnt<=0.
//  Arbitration when packet_enable is accepted; result registered, so packet_type/acks are valid
//   the next cycle (latency 1). packet_type holds until the next accepted grant.
//  Priority: (1) ACR if acr_req && starve_cnt==STARVE_LIMIT; (2) audio if audio_req;
//   (3) ACR if acr_req; (4) InfoFrame with if_pending, searched round-robin from rr_ptr;
//   (5) null, type 0x00. Audio type 0x02, ACR type 0x01.
//  starve_cnt: +1 (saturating) when audio wins while acr_req=1. Cleared when ACR wins or
//   acr_req=0. Width 4 bits.
//  acr_req is a level; the source drops it after acr_ack. Scheduler keeps no ACR state beyond
//   starve_cnt. Same holds for audio_req and audio_ack.
//  if_pending[i]: set to if_enable[i] on video_field_end; cleared on grant of i.
//   A field_end coinciding with a grant of i leaves pending[i]=1 (the new field wins).
//   rr_ptr <= (granted index + 1) mod NUM_IF.
//  field_done = (if_pending==0); combinational from registers. After reset it is 1 only once
//   a field_end has occurred.
//  Overrun: packet_enable in SLOT with slot_cnt!=31 is ignored (no grant, no ack) and sets
//   slot_overrun. Only reset clears it.
//  if_enable changes take effect only at the next video_field_end.
// TESTING
//  1 reset; field_end; 3 slots, no audio/ACR -> types 0x84,0x82,0x83; field_done=1 after 3rd; 4th slot 0x00.
//  2 audio_req=1 and acr_req=1 held, STARVE_LIMIT=4 -> 4 slots 0x02, 5th 0x01 with acr_ack; starve_cnt=0 after.
//  3 audio_req=1 every slot, acr_req=0, field_end -> InfoFrames never granted; field_done stays 0.
//  4 field_end in same cycle as packet_enable granting IF0 -> if_ack[0] pulses, if_pending[0] still 1.
//  5 packet_enable at slot_cnt=10 -> no ack, packet_type unchanged, slot_overrun=1 stays set.
//  6 reset_n low mid-slot (slot_cnt=15) -> outputs return to reset values asynchronously, IDLE on release.

Source files
------------

// File: rtl/packet_scheduler.sv
`timescale 1ns/1ps
// Data-island slot arbiter: picks audio, ACR, round-robin InfoFrame or null for each
// 32-cycle packet slot, with an ACR starvation guard and a sticky slot-overrun flag.
//
//  state | meaning
//  IDLE  | no slot in progress, next packet_enable is accepted
//  SLOT  | slot in progress, slot_cnt counts 0..31; packet_enable only accepted at 31
module packet_scheduler #(
    parameter int                  NUM_IF       = 3,
    parameter logic [8*NUM_IF-1:0] IF_TYPES     = 24'h838284,
    parameter int                  STARVE_LIMIT = 4
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic              video_field_end,
    input  logic              packet_enable,
    input  logic              audio_req,
    output logic              audio_ack,
    input  logic              acr_req,
    output logic              acr_ack,
    input  logic [NUM_IF-1:0] if_enable,
    output logic [NUM_IF-1:0] if_ack,
    output logic [7:0]        packet_type,
    output logic              field_done,
    output logic              slot_overrun
);

    localparam int PTR_W = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;
    localparam int IDX_W = PTR_W + 1;
    localparam logic [7:0] TYPE_NULL  = 8'h00;
    localparam logic [7:0] TYPE_ACR   = 8'h01;
    localparam logic [7:0] TYPE_AUDIO = 8'h02;

    typedef enum logic {IDLE, SLOT} state_t;

    state_t            state;
    logic [4:0]        slot_cnt;
    logic [3:0]        starve_cnt;
    logic [NUM_IF-1:0] if_pending;
    logic [PTR_W-1:0]  rr_ptr;
    logic              field_seen;

    logic              accept;
    logic              overrun_hit;
    logic              starve_hit;
    logic              grant_acr;
    logic              grant_audio;
    logic              grant_if;
    logic              if_found;
    logic [PTR_W-1:0]  if_sel;
    logic [IDX_W-1:0]  idx;
    logic [PTR_W-1:0]  rr_next;
    logic [7:0]        if_type;

    assign accept      = packet_enable && ((state == IDLE) || (slot_cnt == 5'd31));
    assign overrun_hit = packet_enable && !accept;

    // Round-robin search over pending InfoFrames, starting at rr_ptr.
    always_comb begin
        if_found = 1'b0;
        if_sel   = '0;
        idx      = '0;
        for (int k = 0; k < NUM_IF; k++) begin
            idx = IDX_W'(rr_ptr) + IDX_W'(k);
            if (idx >= IDX_W'(NUM_IF)) begin
                idx = idx - IDX_W'(NUM_IF);
            end
            if (!if_found && if_pending[idx[PTR_W-1:0]]) begin
                if_found = 1'b1;
                if_sel   = idx[PTR_W-1:0];
            end
        end
    end

    assign starve_hit  = acr_req && (starve_cnt == 4'(STARVE_LIMIT));
    assign grant_acr   = starve_hit || (!audio_req && acr_req);
    assign grant_audio = audio_req && !starve_hit;
    assign grant_if    = !audio_req && !acr_req && if_found;
    assign rr_next     = (if_sel == PTR_W'(NUM_IF - 1)) ? '0 : if_sel + 1'b1;
    assign if_type     = IF_TYPES[{if_sel, 3'b000} +: 8];

    // Stays low after reset until the first field has loaded the pending mask.
    assign field_done = field_seen && (if_pending == '0);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            starve_cnt   <= '0;
            if_pending   <= '0;
            rr_ptr       <= '0;
            field_seen   <= 1'b0;
            packet_type  <= TYPE_NULL;
            audio_ack    <= 1'b0;
            acr_ack      <= 1'b0;
            if_ack       <= '0;
            slot_overrun <= 1'b0;
        end else begin
            audio_ack <= 1'b0;
            acr_ack   <= 1'b0;
            if_ack    <= '0;

            if (overrun_hit) begin
                slot_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SLOT;
                        slot_cnt <= '0;
                    end
                end
                SLOT: begin
                    if (accept) begin
                        slot_cnt <= '0;
                    end else if (slot_cnt == 5'd31) begin
                        state    <= IDLE;
                        slot_cnt <= '0;
                    end else begin
                        slot_cnt <= slot_cnt + 5'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    slot_cnt <= '0;
                end
            endcase

            if (accept) begin
                if (grant_acr) begin
                    packet_type <= TYPE_ACR;
                    acr_ack     <= 1'b1;
                end else if (grant_audio) begin
                    packet_type <= TYPE_AUDIO;
                    audio_ack   <= 1'b1;
                end else if (grant_if) begin
                    packet_type <= if_type;
                    if_ack      <= NUM_IF'(1) << if_sel;
                    rr_ptr      <= rr_next;
                end else begin
                    packet_type <= TYPE_NULL;
                end
            end

            if (!acr_req) begin
                starve_cnt <= '0;
            end else if (accept) begin
                if (grant_acr) begin
                    starve_cnt <= '0;
                end else if (grant_audio && (starve_cnt != 4'hf)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end

            // A new field reloads the mask even if the same InfoFrame is granted now.
            if (video_field_end) begin
                if_pending <= if_enable;
                field_seen <= 1'b1;
            end else if (accept && grant_if) begin
                if_pending[if_sel] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packet_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for packet_scheduler: stimulus queues expected grants, a monitor
// compares them on the cycle after each packet_enable.
module tb_packet_scheduler;

    logic       clk_pixel = 1'b0;
    logic       reset_n = 1'b0;
    logic       video_field_end = 1'b0;
    logic       packet_enable = 1'b0;
    logic       audio_req = 1'b0;
    logic       acr_req = 1'b0;
    logic [2:0] if_enable = 3'b000;
    logic       audio_ack;
    logic       acr_ack;
    logic [2:0] if_ack;
    logic [7:0] packet_type;
    logic       field_done;
    logic       slot_overrun;

    packet_scheduler #(
        .NUM_IF(3),
        .IF_TYPES(24'h838284),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset_n(reset_n),
        .video_field_end(video_field_end),
        .packet_enable(packet_enable),
        .audio_req(audio_req),
        .audio_ack(audio_ack),
        .acr_req(acr_req),
        .acr_ack(acr_ack),
        .if_enable(if_enable),
        .if_ack(if_ack),
        .packet_type(packet_type),
        .field_done(field_done),
        .slot_overrun(slot_overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [7:0] ptype;
        logic       a;
        logic       r;
        logic [2:0] ifa;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    logic pe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input logic [7:0] t, input logic a, input logic r,
                                input logic [2:0] i, input string n);
        exp_t e;
        e.ptype = t;
        e.a     = a;
        e.r     = r;
        e.ifa   = i;
        e.name  = n;
        sb.push_back(e);
    endtask

    // One full slot: packet_enable pulse then 31 idle cycles, so consecutive calls are back-to-back.
    task automatic slot(input logic [7:0] t, input logic a, input logic r, input logic [2:0] i,
                        input string n, input logic fe = 1'b0);
        expect_grant(t, a, r, i, n);
        packet_enable   = 1'b1;
        video_field_end = fe;
        @(posedge clk_pixel);
        #1;
        packet_enable   = 1'b0;
        video_field_end = 1'b0;
        repeat (31) @(posedge clk_pixel);
        #1;
    endtask

    always @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) pe_prev <= 1'b0;
        else          pe_prev <= packet_enable;
    end

    always @(negedge clk_pixel) begin
        if (reset_n && pe_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got type %0h with no expected entry", packet_type);
            end else begin
                cur = sb.pop_front();
                check({cur.name, "_type"}, 32'(packet_type), 32'(cur.ptype));
                check({cur.name, "_acks"}, 32'({audio_ack, acr_ack, if_ack}),
                      32'({cur.a, cur.r, cur.ifa}));
            end
        end else if (reset_n) begin
            check("idle_acks", 32'({audio_ack, acr_ack, if_ack}), 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_pixel);
        #1;
        check("rst_type", 32'(packet_type), 32'h00);
        check("rst_acks", 32'({audio_ack, acr_ack, if_ack}), 32'd0);
        check("rst_field_done", 32'(field_done), 32'd0);
        check("rst_overrun", 32'(slot_overrun), 32'd0);

        // InfoFrames in round-robin order, then null
        if_enable = 3'b111;
        reset_n   = 1'b1;
        @(posedge clk_pixel);
        #1;
        video_field_end = 1'b1;
        @(posedge clk_pixel);
        #1;
        video_field_end = 1'b0;
        check("fd_after_field_end", 32'(field_done), 32'd0);
        slot(8'h84, 1'b0, 1'b0, 3'b001, "if0");
        slot(8'h82, 1'b0, 1'b0, 3'b010, "if1");
        check("fd_after_if1", 32'(field_done), 32'd0);
        slot(8'h83, 1'b0, 1'b0, 3'b100, "if2");
        check("fd_after_if2", 32'(field_done), 32'd1);
        slot(8'h00, 1'b0, 1'b0, 3'b000, "null1");

        // Starvation guard
        audio_req = 1'b1;
        acr_req   = 1'b1;
        repeat (4) slot(8'h02, 1'b1, 1'b0, 3'b000, "aud_starve");
        slot(8'h01, 1'b0, 1'b1, 3'b000, "acr_forced");
        slot(8'h02, 1'b1, 1'b0, 3'b000, "aud_after_acr");
        acr_req = 1'b0;
        @(posedge clk_pixel);
        #1;
        acr_req = 1'b1;
        repeat (4) slot(8'h02, 1'b1, 1'b0, 3'b000, "aud_after_clear");
        slot(8'h01, 1'b0, 1'b1, 3'b000, "acr_forced2");
        audio_req = 1'b0;
        slot(8'h01, 1'b0, 1'b1, 3'b000, "acr_plain");
        acr_req = 1'b0;
        slot(8'h00, 1'b0, 1'b0, 3'b000, "null2");

        // Audio always present starves InfoFrames
        audio_req = 1'b1;
        video_field_end = 1'b1;
        @(posedge clk_pixel);
        #1;
        video_field_end = 1'b0;
        repeat (3) begin
            slot(8'h02, 1'b1, 1'b0, 3'b000, "aud_blocks_if");
            check("fd_audio_blocks", 32'(field_done), 32'd0);
        end
        audio_req = 1'b0;

        // field_end coincident with IF0 grant keeps IF0 pending
        slot(8'h84, 1'b0, 1'b0, 3'b001, "if0_fe", 1'b1);
        slot(8'h82, 1'b0, 1'b0, 3'b010, "if1_b");
        slot(8'h83, 1'b0, 1'b0, 3'b100, "if2_b");
        check("fd_if0_kept", 32'(field_done), 32'd0);
        slot(8'h84, 1'b0, 1'b0, 3'b001, "if0_again");
        check("fd_after_if0_again", 32'(field_done), 32'd1);

        // Overrun: packet_enable seen at slot_cnt=10
        audio_req = 1'b1;
        expect_grant(8'h02, 1'b1, 1'b0, 3'b000, "aud_pre_ovr");
        packet_enable = 1'b1;
        @(posedge clk_pixel);
        #1;
        packet_enable = 1'b0;
        repeat (10) @(posedge clk_pixel);
        #1;
        check("ovr_before", 32'(slot_overrun), 32'd0);
        expect_grant(8'h02, 1'b0, 1'b0, 3'b000, "ovr_ignored");
        packet_enable = 1'b1;
        @(posedge clk_pixel);
        #1;
        packet_enable = 1'b0;
        check("ovr_set", 32'(slot_overrun), 32'd1);
        repeat (25) @(posedge clk_pixel);
        #1;
        audio_req = 1'b0;
        acr_req   = 1'b1;
        slot(8'h01, 1'b0, 1'b1, 3'b000, "acr_post_ovr");
        acr_req = 1'b0;
        check("ovr_sticky", 32'(slot_overrun), 32'd1);

        // Asynchronous reset at slot_cnt=15
        acr_req = 1'b1;
        expect_grant(8'h01, 1'b0, 1'b1, 3'b000, "acr_pre_rst");
        packet_enable = 1'b1;
        @(posedge clk_pixel);
        #1;
        packet_enable = 1'b0;
        repeat (15) @(posedge clk_pixel);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_type", 32'(packet_type), 32'h00);
        check("arst_acks", 32'({audio_ack, acr_ack, if_ack}), 32'd0);
        check("arst_overrun", 32'(slot_overrun), 32'd0);
        check("arst_field_done", 32'(field_done), 32'd0);
        acr_req = 1'b0;
        @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;
        @(posedge clk_pixel);
        #1;
        audio_req = 1'b1;
        slot(8'h02, 1'b1, 1'b0, 3'b000, "aud_post_rst");
        audio_req = 1'b0;
        check("overrun_post_rst", 32'(slot_overrun), 32'd0);

        repeat (2) @(posedge clk_pixel);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
